// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver:
// one-hot state bit positions, the matching state encoding, and default
// framing parameters.
package uart_pkg;

    // One-hot bit positions inside the state register
    localparam int IDLE  = 0;
    localparam int START = 1;
    localparam int DATA  = 2;
    localparam int STOP  = 3;

    localparam int NUM_STATES = 4;

    // Default framing: 16x oversampling, 8 data bits
    localparam int OVERSAMPLE_DEF = 16;
    localparam int DATA_BITS_DEF  = 8;

    // One-hot state encoding built from the bit positions above
    typedef enum logic [NUM_STATES-1:0] {
        ST_IDLE  = NUM_STATES'(1 << IDLE),
        ST_START = NUM_STATES'(1 << START),
        ST_DATA  = NUM_STATES'(1 << DATA),
        ST_STOP  = NUM_STATES'(1 << STOP)
    } state_t;

endpackage

// File: rtl/uart_tx.sv
// UART transmitter: single-entry holding register feeding an 8N1 (or 8N2)
// shifter timed by the shared oversampling baud tick. A byte waiting in the
// holding register is started on the same edge the previous stop bit ends,
// so back-to-back frames have no idle gap.
module uart_tx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEF,
    parameter int DATA_BITS  = DATA_BITS_DEF,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 brg_tick,
    input  logic [DATA_BITS-1:0] d,
    input  logic                 tx_write_tick,
    output logic                 tx,
    output logic                 tx_ready,
    output logic                 tx_done_tick,
    output logic                 tx_idle
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    // Holding register
    logic [DATA_BITS-1:0] thr_q;
    logic                 thr_full_q;
    logic                 thr_full_d;
    logic                 ready_q;

    // Shifter and frame sequencing
    state_t               state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [TICK_W-1:0]    tick_cnt_q;
    logic [BIT_W-1:0]     bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 tx_q;
    logic                 done_q;
    logic                 idle_q;

    // Decoded events for the current cycle
    logic bit_end;
    logic last_stop;
    logic frame_end;
    logic load;
    logic wr_accept;
    logic idle_next;

    // A bit period closes on the tick that finds the counter at its last value
    assign bit_end   = brg_tick && (tick_cnt_q == TICK_LAST);
    assign last_stop = (stop_cnt_q == STOP_LAST);
    assign frame_end = state_q[STOP] && bit_end && last_stop;

    // Transfer holding register into the shifter: from IDLE on any tick, or
    // straight out of the final stop bit when another byte is waiting
    assign load      = thr_full_q && ((state_q[IDLE] && brg_tick) || frame_end);

    // Writes only land in an empty holding register; others are dropped
    assign wr_accept = tx_write_tick && !thr_full_q;

    // Next holding-register flag; load and accepted write are mutually
    // exclusive because load needs the register full and a write needs it empty
    always_comb begin
        thr_full_d = thr_full_q;
        if (load) begin
            thr_full_d = 1'b0;
        end else if (wr_accept) begin
            thr_full_d = 1'b1;
        end
    end

    // Next value of tx_idle: the shifter is (or returns to) IDLE and the
    // holding register will be empty after this edge
    assign idle_next = ((state_q[IDLE] && !load) || (frame_end && !thr_full_q))
                       && !thr_full_d;

    // Holding register and its registered ready flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thr_q      <= '0;
            thr_full_q <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            thr_full_q <= thr_full_d;
            ready_q    <= !thr_full_d;
            if (wr_accept) begin
                thr_q <= d;
            end
        end
    end

    // Frame FSM: sequences start, data and stop bits and drives the line
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            idle_q     <= 1'b1;
        end else begin
            done_q <= 1'b0;
            idle_q <= idle_next;

            unique case (state_q)
                ST_IDLE: begin
                    tx_q <= 1'b1;
                    if (load) begin
                        shift_q    <= thr_q;
                        tick_cnt_q <= '0;
                        tx_q       <= 1'b0;
                        state_q    <= ST_START;
                    end
                end

                ST_START: begin
                    if (brg_tick) begin
                        if (bit_end) begin
                            tick_cnt_q <= '0;
                            bit_cnt_q  <= '0;
                            tx_q       <= shift_q[0];
                            state_q    <= ST_DATA;
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                ST_DATA: begin
                    if (brg_tick) begin
                        if (bit_end) begin
                            tick_cnt_q <= '0;
                            if (bit_cnt_q == BIT_LAST) begin
                                tx_q       <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                state_q    <= ST_STOP;
                            end else begin
                                // Next bit is shift_q[1], which becomes bit 0 after the shift
                                shift_q   <= shift_q >> 1;
                                tx_q      <= shift_q[1];
                                bit_cnt_q <= bit_cnt_q + 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                ST_STOP: begin
                    if (brg_tick) begin
                        if (bit_end) begin
                            tick_cnt_q <= '0;
                            if (last_stop) begin
                                done_q     <= 1'b1;
                                stop_cnt_q <= 1'b0;
                                if (load) begin
                                    shift_q <= thr_q;
                                    tx_q    <= 1'b0;
                                    state_q <= ST_START;
                                end else begin
                                    tx_q    <= 1'b1;
                                    state_q <= ST_IDLE;
                                end
                            end else begin
                                stop_cnt_q <= stop_cnt_q + 1'b1;
                            end
                        end else begin
                            tick_cnt_q <= tick_cnt_q + 1'b1;
                        end
                    end
                end

                default: begin
                    tx_q    <= 1'b1;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_ready     = ready_q;
    assign tx_done_tick = done_q;
    assign tx_idle      = idle_q;

endmodule
